// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register.
// Keeps one instruction-memory request outstanding at most. The register holds its contents
// while stalled and is flushed on a taken branch. A single-entry skid buffer parks a response
// that returns during a stall.
// Optional feature: define FETCH_PERF_EN to build the delivered-instruction and stall-cycle
// counters. Without it, both perf ports are tied to zero.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_ip,
    input  logic        branch_taken_ip,
    input  logic [31:0] branch_target_ip,
    output logic        imem_req_op,
    output logic [31:0] imem_addr_op,
    input  logic        imem_gnt_ip,
    input  logic        imem_rvalid_ip,
    input  logic [31:0] imem_rdata_ip,
    output logic [31:0] ID_instr_op,
    output logic [31:0] ID_pc_op,
    output logic        ID_valid_op,
    output logic [6:0]  ID_instr_opcode_op,
    output logic [4:0]  ID_src1_addr_op,
    output logic [4:0]  ID_src2_addr_op,
    output logic [31:0] perf_fetch_cnt_op,
    output logic [31:0] perf_stall_cnt_op
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;

    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;
    logic        accept;
    logic [31:0] redirect_pc;

    // The skid buffer needs no separate flag because it is full exactly while the FSM is in HOLD.
    assign accept      = (state == S_REQ) && imem_gnt_ip;
    assign redirect_pc = branch_target_ip & ~32'h3;

    assign imem_req_op  = (state == S_REQ);
    assign imem_addr_op = fetch_pc;

    assign ID_instr_op        = id_instr;
    assign ID_pc_op           = id_pc;
    assign ID_valid_op        = id_valid;
    assign ID_instr_opcode_op = id_instr[6:0];
    assign ID_src1_addr_op    = id_instr[19:15];
    assign ID_src2_addr_op    = id_instr[24:20];

    // Next-state and delivery decision; redirect overrides stall and normal transitions
    always_comb begin
        state_nxt     = state;
        deliver       = 1'b0;
        deliver_instr = imem_rdata_ip;
        deliver_pc    = rsp_pc;
        if (branch_taken_ip) begin
            case (state)
                S_REQ:   state_nxt = imem_gnt_ip    ? S_DRAIN : S_REQ;
                S_WAIT:  state_nxt = imem_rvalid_ip ? S_REQ   : S_DRAIN;
                S_HOLD:  state_nxt = S_REQ;
                default: state_nxt = imem_rvalid_ip ? S_REQ   : S_DRAIN;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_gnt_ip) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_ip) begin
                        if (stall_ip) begin
                            state_nxt = S_HOLD;
                        end else begin
                            deliver   = 1'b1;
                            state_nxt = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_ip) begin
                        deliver       = 1'b1;
                        deliver_instr = skid_instr;
                        deliver_pc    = skid_pc;
                        state_nxt     = S_REQ;
                    end
                end
                default: begin
                    if (imem_rvalid_ip) state_nxt = S_REQ;
                end
            endcase
        end
    end

    // Fetch PC, response tracking, skid buffer and IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            rsp_pc     <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            id_instr   <= NOP_INSTR;
            id_pc      <= '0;
            id_valid   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (branch_taken_ip) begin
                fetch_pc <= redirect_pc;
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (accept) begin
                rsp_pc <= fetch_pc;
            end

            if (!branch_taken_ip && (state == S_WAIT) && imem_rvalid_ip && stall_ip) begin
                skid_instr <= imem_rdata_ip;
                skid_pc    <= rsp_pc;
            end

            if (branch_taken_ip) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end else if (deliver) begin
                id_instr <= deliver_instr;
                id_pc    <= deliver_pc;
                id_valid <= 1'b1;
            end else if (!stall_ip) begin
                id_instr <= NOP_INSTR;
                id_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    // Delivered-instruction and stall-cycle counters, both wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (deliver)  fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_ip) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt_op = fetch_cnt;
    assign perf_stall_cnt_op = stall_cnt;
`else
    assign perf_fetch_cnt_op = '0;
    assign perf_stall_cnt_op = '0;
`endif

endmodule
